// File: rtl/multiplier_reg_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package multiplier_reg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mul_state_t;

   localparam int DEFAULT_BITWIDTH = 8;

   // Iteration counter width; never narrower than one bit.
   function automatic int cntWidth(input int width);
      if ($clog2(width) < 1) begin
         return 1;
      end else begin
         return $clog2(width);
      end
   endfunction

endpackage

// File: rtl/multiplier_reg_if.sv
// Request/result bundle of the multiplier: start, clear, operands and held product.
interface multiplier_reg_if
   import multiplier_reg_pkg::*;
#(
   parameter int BITWIDTH = DEFAULT_BITWIDTH
);

   logic                  iEn;
   logic                  iClr;
   logic [BITWIDTH-1:0]   iData0;
   logic [BITWIDTH-1:0]   iData1;
   logic [2*BITWIDTH-1:0] oData;

   modport master (
      output iEn,
      output iClr,
      output iData0,
      output iData1,
      input  oData
   );

   modport slave (
      input  iEn,
      input  iClr,
      input  iData0,
      input  iData1,
      output oData
   );

endinterface

// File: rtl/multiplier_reg_dp.sv
// Shift-add datapath: multiplicand shifts left, multiplier shifts right, accumulator
// adds the multiplicand whenever the multiplier LSB is set.
module mul_shift_add_dp
   import multiplier_reg_pkg::*;
#(
   parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
   input  logic                  iClk,
   input  logic                  iRstN,
   input  logic                  load,
   input  logic                  step,
   input  logic                  clr,
   input  logic [BITWIDTH-1:0]   data0,
   input  logic [BITWIDTH-1:0]   data1,
   output logic [2*BITWIDTH-1:0] nextAcc
);

   logic [2*BITWIDTH-1:0] aR;
   logic [BITWIDTH-1:0]   bR;
   logic [2*BITWIDTH-1:0] accR;
   logic [2*BITWIDTH-1:0] addendS;

   // Partial-product select and running sum for the current iteration.
   always_comb begin
      addendS = '0;
      if (bR[0]) begin
         addendS = aR;
      end else begin
         addendS = '0;
      end
      nextAcc = accR + addendS;
   end

   // Operand shift registers and accumulator; clear keeps the operands.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         aR   <= '0;
         bR   <= '0;
         accR <= '0;
      end else if (clr) begin
         accR <= '0;
      end else if (load) begin
         aR   <= {{BITWIDTH{1'b0}}, data0};
         bR   <= data1;
         accR <= '0;
      end else if (step) begin
         aR   <= {aR[2*BITWIDTH-2:0], 1'b0};
         bR   <= {1'b0, bR[BITWIDTH-1:1]};
         accR <= nextAcc;
      end else begin
         aR   <= aR;
         bR   <= bR;
         accR <= accR;
      end
   end

endmodule

// File: rtl/multiplier_reg.sv
// Iterative unsigned multiplier: capture in IDLE, BITWIDTH shift-add steps in BUSY,
// product registered on the final step and held until the next result or a clear.
module multiplier_reg
   import multiplier_reg_pkg::*;
#(
   parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
   input  logic           iClk,
   input  logic           iRstN,
   multiplier_reg_if.slave bus
);

   localparam int CW = cntWidth(BITWIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(BITWIDTH - 1);

   mul_state_t            stateR;
   logic [CW-1:0]         countR;
   logic [2*BITWIDTH-1:0] oDataR;
   logic [2*BITWIDTH-1:0] nextAccS;
   logic                  loadS;
   logic                  stepS;

   // Datapath strobes; clear overrides any capture on the same edge.
   always_comb begin
      loadS = 1'b0;
      stepS = 1'b0;
      if ((stateR == IDLE) && bus.iEn && !bus.iClr) begin
         loadS = 1'b1;
      end else begin
         loadS = 1'b0;
      end
      if (stateR == BUSY) begin
         stepS = 1'b1;
      end else begin
         stepS = 1'b0;
      end
   end

   mul_shift_add_dp #(
      .BITWIDTH (BITWIDTH)
   ) uDp (
      .iClk    (iClk),
      .iRstN   (iRstN),
      .load    (loadS),
      .step    (stepS),
      .clr     (bus.iClr),
      .data0   (bus.iData0),
      .data1   (bus.iData1),
      .nextAcc (nextAccS)
   );

   // Control FSM, iteration counter and held product register.
   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         stateR <= IDLE;
         countR <= '0;
         oDataR <= '0;
      end else if (bus.iClr) begin
         stateR <= IDLE;
         countR <= '0;
         oDataR <= '0;
      end else begin
         case (stateR)
            IDLE: begin
               countR <= '0;
               if (bus.iEn) begin
                  stateR <= BUSY;
               end else begin
                  stateR <= IDLE;
               end
            end
            BUSY: begin
               if (countR == LAST_COUNT) begin
                  oDataR <= nextAccS;
                  countR <= '0;
                  stateR <= IDLE;
               end else begin
                  countR <= countR + CW'(1);
                  stateR <= BUSY;
               end
            end
            default: begin
               stateR <= IDLE;
               countR <= '0;
            end
         endcase
      end
   end

   assign bus.oData = oDataR;

endmodule

// File: tb/tb_multiplier_reg.sv
// Directed and randomized bench for multiplier_reg against a plain a*b reference.
module tb_multiplier_reg;

   localparam int BW = 8;

   logic iClk;
   logic iRstN;
   int   nVec;
   int   nMis;
   logic [2*BW-1:0] expOut;

   multiplier_reg_if #(.BITWIDTH(BW)) bus ();

   multiplier_reg #(.BITWIDTH(BW)) dut (
      .iClk  (iClk),
      .iRstN (iRstN),
      .bus   (bus)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic edge1();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2*BW-1:0] obs, input logic [2*BW-1:0] exp);
      nVec++;
      assert (obs === exp)
      else begin
         nMis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [2*BW-1:0] refMul(input int unsigned a, input int unsigned b);
      int unsigned p;
      p = a * b;
      return p[2*BW-1:0];
   endfunction

   // Assumes the DUT is idle; capture on the next edge, hold for BW-1 edges, result on edge BW.
   task automatic doMul(input int unsigned a, input int unsigned b, input bit garbage, input string tag);
      bus.iData0 = a[BW-1:0];
      bus.iData1 = b[BW-1:0];
      bus.iEn    = 1'b1;
      bus.iClr   = 1'b0;
      edge1();
      for (int k = 1; k < BW; k++) begin
         if (garbage) begin
            bus.iEn    = 1'($urandom_range(1, 0));
            bus.iData0 = 8'($urandom);
            bus.iData1 = 8'($urandom);
         end
         edge1();
         chk({tag, "_hold"}, bus.oData, expOut);
      end
      edge1();
      expOut = refMul(a, b);
      chk(tag, bus.oData, expOut);
      bus.iEn = 1'b0;
   endtask

   initial begin
      nVec       = 0;
      nMis       = 0;
      expOut     = '0;
      iRstN      = 1'b0;
      bus.iEn    = 1'b1;
      bus.iClr   = 1'b0;
      bus.iData0 = 8'd10;
      bus.iData1 = 8'd20;

      // Reset held with a pending request
      for (int i = 0; i < 2; i++) begin
         edge1();
         chk("reset", bus.oData, 16'd0);
      end

      // Release reset with iEn held: capture, 200 after BW edges, then held across a recapture
      iRstN = 1'b1;
      edge1();
      for (int k = 1; k < BW; k++) begin
         edge1();
         chk("basic_lat", bus.oData, 16'd0);
      end
      edge1();
      expOut = refMul(10, 20);
      chk("basic_200", bus.oData, 16'd200);
      for (int k = 0; k < BW; k++) begin
         edge1();
         chk("basic_held", bus.oData, expOut);
      end

      // Clear with iEn high zeroes the held result and blocks capture
      bus.iClr = 1'b1;
      for (int i = 0; i < 40; i++) begin
         edge1();
         chk("clr_zero", bus.oData, 16'd0);
      end
      expOut   = '0;
      bus.iClr = 1'b0;
      edge1();
      for (int k = 1; k < BW; k++) begin
         edge1();
         chk("clr_recap_lat", bus.oData, 16'd0);
      end
      edge1();
      expOut = refMul(10, 20);
      chk("clr_recap_200", bus.oData, 16'd200);
      bus.iEn = 1'b0;
      edge1();
      chk("idle_hold", bus.oData, expOut);

      // Corners
      doMul(255, 255, 1'b0, "max_max");
      chk("max_max_val", expOut, 16'd65025);
      doMul(0, 200, 1'b0, "zero_x");
      doMul(1, 173, 1'b0, "one_x");
      doMul(128, 2, 1'b0, "carry_256");

      // Operands change mid-BUSY; iEn held so 9*9 follows straight after
      bus.iData0 = 8'd3;
      bus.iData1 = 8'd7;
      bus.iEn    = 1'b1;
      edge1();
      for (int k = 1; k < BW; k++) begin
         edge1();
         if (k == 3) begin
            bus.iData0 = 8'd9;
            bus.iData1 = 8'd9;
         end
         chk("latch_hold", bus.oData, expOut);
      end
      edge1();
      chk("latch_21", bus.oData, 16'd21);
      expOut = 16'd21;
      edge1();
      for (int k = 1; k < BW; k++) begin
         edge1();
         chk("next_hold", bus.oData, expOut);
      end
      edge1();
      chk("next_81", bus.oData, 16'd81);
      expOut  = 16'd81;
      bus.iEn = 1'b0;

      // Abort on the fourth BUSY cycle, then a fresh operation with full latency
      bus.iData0 = 8'd11;
      bus.iData1 = 8'd13;
      bus.iEn    = 1'b1;
      edge1();
      bus.iEn = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         edge1();
         chk("abort_pre", bus.oData, expOut);
      end
      bus.iClr = 1'b1;
      edge1();
      expOut = '0;
      chk("abort_zero", bus.oData, expOut);
      bus.iClr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         edge1();
         chk("abort_idle", bus.oData, expOut);
      end
      doMul(6, 5, 1'b0, "fresh_30");

      // Random operands, garbage inputs while busy, random idle gaps with optional clear
      for (int n = 0; n < 30; n++) begin
         int unsigned gap;
         gap = $urandom_range(3, 0);
         for (int g = 0; g < int'(gap); g++) begin
            bus.iEn  = 1'b0;
            bus.iClr = ($urandom_range(3, 0) == 0);
            edge1();
            if (bus.iClr) begin
               expOut = '0;
            end
            chk("rand_gap", bus.oData, expOut);
         end
         bus.iClr = 1'b0;
         doMul($urandom_range(255, 0), $urandom_range(255, 0), 1'b1, "rand_mul");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
